chacha_stream_xor: RTL and testbench
====================================

Name: chacha_stream_xor

Overview:
- Streaming ChaCha keystream engine with XOR datapath. Successor to the register-mapped single-block chacha core.
- Takes key, nonce and starting block counter, then generates successive 512-bit keystream blocks with automatic counter increment.
- XORs each keystream block onto a valid/ready data stream of configurable beat width.
- Parametrised in round count, counter/nonce mode (IETF 32-bit counter or original 64-bit counter) and data width. Sits between a DMA/stream source and sink, below the register front-end.

Parameters:
ROUNDS, 20, total rounds; must be even (8, 12 or 20 supported).
CTR_W, 32, block counter width: 32 = IETF (96-bit nonce), 64 = original (64-bit nonce, nonce[95:64] ignored).
DATA_W, 32, stream beat width; must be 32, 64 or 128. BEATS = 512/DATA_W.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
init  in  1  single-cycle pulse: load key/nonce/ctr_init, start block generation
key  in  256  key words; key[32*i+31:32*i] = state word 4+i
nonce  in  96  nonce; word 0 in nonce[31:0]
ctr_init  in  64  starting block counter; upper 32 bits ignored when CTR_W=32
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
in_data  in  DATA_W  plaintext/ciphertext beat
in_last  in  1  final beat of message
out_valid  out  1  output beat valid
out_ready  in  1  sink ready
out_data  out  DATA_W  in_data XOR keystream
out_last  out  1  copy of in_last for this beat
busy  out  1  state != IDLE or out_valid
ctr_overflow  out  1  sticky; 32-bit counter exhausted; cleared by init or reset

Behaviour:
- Reset values:
  - in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, ctr_overflow=0.
  - FSM=IDLE; counter, key and nonce registers = 0.
- State words 0-3 are 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574. Words 4-11 are the key.
- CTR_W=32: word12 = ctr[31:0]; words 13-15 = nonce[31:0], [63:32], [95:64].
- CTR_W=64: words 12-13 = ctr[31:0], ctr[63:32]; words 14-15 = nonce[31:0], [63:32].
- FSM: IDLE -> ROUND -> FINAL -> STREAM.
  - IDLE: in_ready=0. init latches key/nonce/ctr_init, builds the state, goes to ROUND.
  - ROUND: one half-round per cycle, four parallel quarter-rounds. Even cycles are column rounds, odd cycles are diagonal rounds. Exactly ROUNDS cycles.
  - FINAL: 1 cycle; adds the input state word-wise mod 2^32 into the keystream buffer; beat index = 0.
  - STREAM: in_ready = !out_valid | out_ready.
- First in_ready is asserted ROUNDS+2 cycles after the init cycle (22 for ROUNDS=20).
- Beat mapping: beat k XORs keystream words k*DATA_W/32 upward; the lowest word maps to bits [31:0].
- Output is a registered stage, latency 1: the accepted beat appears on out_data/out_last the next cycle and holds stable until out_ready.
- Block rollover: when beat BEATS-1 is accepted without in_last, the counter increments and the FSM goes to ROUND with the new state. in_ready is 0 during regeneration; there is no keystream prefetch.
- in_last accepted: the remaining keystream is discarded and the FSM goes to IDLE. The counter is left at (block used)+1, but the next init reloads it anyway.
- Counter width: CTR_W=32 increments only ctr[31:0]. CTR_W=64 carries into word13.
- Overflow (CTR_W=32 only): rollover with ctr[31:0]=0xFFFFFFFF sets ctr_overflow and goes to IDLE. Further input is refused (in_ready=0) until init. CTR_W=64 wraps silently.
- init in any non-IDLE state aborts: out_valid is cleared, the buffered beat is dropped, and generation restarts with the new parameters.
- init has priority over a simultaneous beat handshake.
- Asynchronous reset mid-operation returns everything to reset values immediately.
- Input acceptance in STREAM is independent of in_valid; out_valid never drops without out_ready.

Test Plan:
- RFC 8439 §2.3.2 vector, CTR_W=32, ROUNDS=20: key bytes 00..1f (key word0=0x03020100), nonce={0x00000000, 0x4a000000, 0x09000000}, ctr_init=1, 16 zero beats with last on beat 15 -> out words 0xe4e7f110, 0x15593bd1, 0x1fdd0f50, ..., 0x4e3c50a2; first in_ready 22 cycles after init.
- All-zero key, nonce and ctr, 32 zero beats, no last until beat 31 -> beat0=0xade0b876, beat1=0x903df1a0. in_ready is low for exactly 22 cycles between beats 15 and 16; beats 16-31 equal block counter=1 keystream.
- Backpressure: out_ready random 50% during the RFC vector -> identical data, no beat lost or duplicated, out_data stable while stalled.
- CTR_W=32, ctr_init=0xFFFFFFFF, 17 beats offered -> 16 beats pass, ctr_overflow=1, in_ready stays 0, busy drops once the output drains. init then clears ctr_overflow.
- init pulse on beat 5 of a block, then reset_n low mid-ROUND -> output cleared, restart matches a fresh run. After reset all outputs = 0 and state = IDLE.
- DATA_W=128, ROUNDS=8 and CTR_W=64 builds, compared against a reference model -> 4 beats per block, counter carry 0x00000000FFFFFFFF -> 0x0000000100000000 verified.

Source files
------------

// File: rtl/chacha_stream_xor.sv
// chacha_stream_xor: streaming ChaCha keystream engine.
// Generates 512-bit blocks and XORs them onto a valid/ready beat stream.
module chacha_stream_xor #(
  parameter int ROUNDS = 20,
  parameter int CTR_W  = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init,
  input  logic [255:0]      key,
  input  logic [95:0]       nonce,
  input  logic [63:0]       ctr_init,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              ctr_overflow
);

  localparam int BEATS = 512 / DATA_W;
  localparam int BW    = $clog2(BEATS);
  localparam int SH    = $clog2(DATA_W);
  localparam int RW    = $clog2(ROUNDS);

  localparam logic [127:0] SIGMA = {
    32'h6b206574, 32'h79622d32,
    32'h3320646e, 32'h61707865
  };

  typedef enum logic [1:0] {
    IDLE, ROUND, FINAL, STREAM
  } state_e;

  state_e            state_q, state_d;
  logic [255:0]      key_q, key_d;
  logic [95:0]       nonce_q, nonce_d;
  logic [63:0]       ctr_q, ctr_d;
  logic [511:0]      work_q, work_d;
  logic [511:0]      ks_q, ks_d;
  logic [RW-1:0]     rnd_q, rnd_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              ov_q, ov_d;
  logic [DATA_W-1:0] od_q, od_d;
  logic              ol_q, ol_d;
  logic              ovf_q, ovf_d;

  logic [63:0]       ctr_inc;
  logic [127:0]      tail_cur, tail_new, tail_nxt;
  logic [511:0]      st_cur, st_new, st_nxt;
  logic [511:0]      hround, ks_sum;
  logic [DATA_W-1:0] ks_beat;
  logic [31:0]       wi [16];
  logic [31:0]       wc [16];
  logic [31:0]       wd [16];
  logic              unused_hi;

  function automatic logic [127:0] qr(
    input logic [31:0] a0, b0, c0, d0
  );
    logic [31:0] a, b, c, d;
    a = a0 + b0;
    d = d0 ^ a;
    d = {d[15:0], d[31:16]};
    c = c0 + d;
    b = b0 ^ c;
    b = {b[19:0], b[31:20]};
    a = a + b;
    d = d ^ a;
    d = {d[23:0], d[31:24]};
    c = c + d;
    b = b ^ c;
    b = {b[24:0], b[31:25]};
    return {d, c, b, a};
  endfunction

  if (CTR_W == 32) begin : g_ietf
    assign ctr_inc  = {ctr_q[63:32],
                       ctr_q[31:0] + 32'd1};
    assign tail_cur = {nonce_q, ctr_q[31:0]};
    assign tail_new = {nonce, ctr_init[31:0]};
    assign tail_nxt = {nonce_q, ctr_inc[31:0]};
  end else begin : g_orig
    assign ctr_inc  = ctr_q + 64'd1;
    assign tail_cur = {nonce_q[63:0], ctr_q};
    assign tail_new = {nonce[63:0], ctr_init};
    assign tail_nxt = {nonce_q[63:0], ctr_inc};
  end

  assign unused_hi = ^nonce_q[95:64];

  assign st_cur = {tail_cur, key_q, SIGMA};
  assign st_new = {tail_new, key, SIGMA};
  assign st_nxt = {tail_nxt, key_q, SIGMA};

  assign ks_beat =
    ks_q[{beat_q, {SH{1'b0}}} +: DATA_W];

  // unpack the working state into words
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      wi[i] = work_q[32*i +: 32];
    end
  end

  // column and diagonal half-rounds side by side
  always_comb begin
    wc = wi;
    wd = wi;
    for (int q = 0; q < 4; q++) begin
      {wc[12+q], wc[8+q], wc[4+q], wc[q]} =
        qr(wi[q], wi[4+q], wi[8+q], wi[12+q]);
      {wd[12+(q+3)%4], wd[8+(q+2)%4],
       wd[4+(q+1)%4], wd[q]} =
        qr(wi[q], wi[4+(q+1)%4],
           wi[8+(q+2)%4], wi[12+(q+3)%4]);
    end
  end

  // pick the half-round by cycle parity; final feed-forward add
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      hround[32*i +: 32] = rnd_q[0] ? wd[i] : wc[i];
      ks_sum[32*i +: 32] = work_q[32*i +: 32]
                         + st_cur[32*i +: 32];
    end
  end

  // next-state, handshake and datapath control
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    nonce_d  = nonce_q;
    ctr_d    = ctr_q;
    work_d   = work_q;
    ks_d     = ks_q;
    rnd_d    = rnd_q;
    beat_d   = beat_q;
    ov_d     = ov_q;
    od_d     = od_q;
    ol_d     = ol_q;
    ovf_d    = ovf_q;
    in_ready = 1'b0;

    if (ov_q && out_ready) begin
      ov_d = 1'b0;
    end

    case (state_q)
      ROUND: begin
        work_d = hround;
        rnd_d  = rnd_q + RW'(1);
        if (rnd_q == RW'(ROUNDS - 1)) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        ks_d    = ks_sum;
        beat_d  = '0;
        state_d = STREAM;
      end
      STREAM: begin
        in_ready = (!ov_q || out_ready) && !init;
        if (in_valid && in_ready) begin
          ov_d = 1'b1;
          od_d = in_data ^ ks_beat;
          ol_d = in_last;
          if (in_last) begin
            ctr_d   = ctr_inc;
            state_d = IDLE;
          end else if (beat_q == BW'(BEATS - 1)) begin
            if (CTR_W == 32 && (&ctr_q[31:0])) begin
              ovf_d   = 1'b1;
              state_d = IDLE;
            end else begin
              ctr_d   = ctr_inc;
              work_d  = st_nxt;
              rnd_d   = '0;
              state_d = ROUND;
            end
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      default: ;
    endcase

    // a new init aborts whatever is in flight
    if (init) begin
      key_d   = key;
      nonce_d = nonce;
      ctr_d   = ctr_init;
      work_d  = st_new;
      rnd_d   = '0;
      ov_d    = 1'b0;
      ovf_d   = 1'b0;
      state_d = ROUND;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      nonce_q <= '0;
      ctr_q   <= '0;
      work_q  <= '0;
      ks_q    <= '0;
      rnd_q   <= '0;
      beat_q  <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ol_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      nonce_q <= nonce_d;
      ctr_q   <= ctr_d;
      work_q  <= work_d;
      ks_q    <= ks_d;
      rnd_q   <= rnd_d;
      beat_q  <= beat_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ol_q    <= ol_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid    = ov_q;
  assign out_data     = od_q;
  assign out_last     = ol_q;
  assign busy         = (state_q != IDLE) || ov_q;
  assign ctr_overflow = ovf_q;

endmodule

// File: tb/tb_chacha_stream_xor.sv
// tb_chacha_stream_xor: directed vectors for the ChaCha stream engine.
// Default build plus an 8-round, 64-bit counter, 128-bit beat build.
module tb_chacha_stream_xor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         init;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [63:0]  ctr_init;
  logic         in_valid, in_ready, in_last;
  logic [31:0]  in_data, out_data;
  logic         out_valid, out_last;
  logic         out_ready = 1'b1;
  logic         busy, ctr_overflow;

  logic         init2;
  logic [255:0] key2;
  logic [95:0]  nonce2;
  logic [63:0]  ctr_init2;
  logic         in_valid2, in_ready2, in_last2;
  logic [127:0] in_data2, out_data2;
  logic         out_valid2, out_last2;
  logic         out_ready2 = 1'b1;
  logic         busy2, ovf2;

  chacha_stream_xor u_dut (
    .clk(clk), .reset_n(reset_n), .init(init),
    .key(key), .nonce(nonce), .ctr_init(ctr_init),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .ctr_overflow(ctr_overflow)
  );

  chacha_stream_xor #(
    .ROUNDS(8), .CTR_W(64), .DATA_W(128)
  ) u_dut2 (
    .clk(clk), .reset_n(reset_n), .init(init2),
    .key(key2), .nonce(nonce2), .ctr_init(ctr_init2),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .in_last(in_last2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_last(out_last2),
    .busy(busy2), .ctr_overflow(ovf2)
  );

  typedef struct {
    logic [31:0] din;
    logic        last;
    logic [31:0] exp;
  } vec_t;

  vec_t         tv [32];
  int           tv_n;
  int           acc_at [32];
  logic [31:0]  rfc_ks [16];
  logic [255:0] key_rfc;
  logic [95:0]  nonce_rfc;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit bp_en  = 0;

  logic [32:0]  got_q [$];
  logic [128:0] got2_q [$];
  logic         stall_p = 1'b0;
  logic [31:0]  stall_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, got, exp);
    end
  endtask

  function automatic logic [31:0] rotl(
    input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [511:0] ref_block(
    input logic [255:0] k,
    input logic [31:0] w12, w13, w14, w15,
    input int rounds);
    logic [31:0] s [16];
    logic [31:0] x [16];
    int ia [8], ib [8], ic [8], id [8];
    logic [511:0] r;
    ia = '{0, 1, 2, 3, 0, 1, 2, 3};
    ib = '{4, 5, 6, 7, 5, 6, 7, 4};
    ic = '{8, 9, 10, 11, 10, 11, 8, 9};
    id = '{12, 13, 14, 15, 15, 12, 13, 14};
    s[0] = 32'h61707865; s[1] = 32'h3320646e;
    s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = w12; s[13] = w13; s[14] = w14; s[15] = w15;
    x = s;
    for (int dr = 0; dr < rounds / 2; dr++) begin
      for (int j = 0; j < 8; j++) begin
        x[ia[j]] += x[ib[j]];
        x[id[j]] = rotl(x[id[j]] ^ x[ia[j]], 16);
        x[ic[j]] += x[id[j]];
        x[ib[j]] = rotl(x[ib[j]] ^ x[ic[j]], 12);
        x[ia[j]] += x[ib[j]];
        x[id[j]] = rotl(x[id[j]] ^ x[ia[j]], 8);
        x[ic[j]] += x[id[j]];
        x[ib[j]] = rotl(x[ib[j]] ^ x[ic[j]], 7);
      end
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
    return r;
  endfunction

  // output capture and hold-while-stalled checks
  always @(negedge clk) begin
    if (reset_n) begin
      if (stall_p) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, stall_d);
      end
      if (out_valid && out_ready)
        got_q.push_back({out_last, out_data});
      if (out_valid2 && out_ready2)
        got2_q.push_back({out_last2, out_data2});
      stall_p <= out_valid && !out_ready;
      stall_d <= out_data;
    end else begin
      stall_p <= 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "time limit");
  end

  task automatic pulse_init(input logic [255:0] k,
                            input logic [95:0] n,
                            input logic [63:0] c);
    key = k; nonce = n; ctr_init = c; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] d, input logic l,
                      input int lim, output bit ok,
                      output int at);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    ok = 0; at = -1;
    while (n < lim) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1; at = cyc;
        break;
      end
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_table(input string tag);
    bit ok;
    int at;
    int w = 0;
    got_q.delete();
    for (int i = 0; i < tv_n; i++) begin
      push(tv[i].din, tv[i].last, 300, ok, at);
      acc_at[i] = at;
      check($sformatf("%s_accept%0d", tag, i), ok, 1'b1);
    end
    while (got_q.size() < tv_n && w < 300) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk); #1;
    check($sformatf("%s_count", tag), got_q.size(), tv_n);
    for (int i = 0; i < tv_n && i < got_q.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i),
            got_q[i][31:0], tv[i].exp);
      check($sformatf("%s_last%0d", tag, i),
            got_q[i][32], tv[i].last);
    end
  endtask

  task automatic fill_rfc(input bit pat);
    tv_n = 16;
    for (int i = 0; i < 16; i++) begin
      tv[i].din  = pat ? (32'ha5c30000 + i * 32'h01010101) : 32'h0;
      tv[i].last = (i == 15);
      tv[i].exp  = tv[i].din ^ rfc_ks[i];
    end
  endtask

  task automatic push2(input logic [127:0] d, input logic l,
                       output bit ok);
    int n = 0;
    in_valid2 = 1'b1; in_data2 = d; in_last2 = l; ok = 0;
    while (n < 100) begin
      @(negedge clk);
      if (in_ready2) begin
        ok = 1;
        break;
      end
      n++;
    end
    @(posedge clk); #1;
    in_valid2 = 1'b0;
  endtask

  initial begin
    logic [511:0] blk0, blk1;
    logic [127:0] d2 [8];
    int  n;
    bit  ok;
    int  at;

    rfc_ks = '{
      32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
      32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
      32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
      32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2
    };
    for (int i = 0; i < 8; i++)
      key_rfc[32*i +: 32] = {8'(4*i+3), 8'(4*i+2),
                             8'(4*i+1), 8'(4*i)};
    nonce_rfc = 96'h00000000_4a000000_09000000;

    reset_n = 1'b0; init = 1'b0; key = '0; nonce = '0;
    ctr_init = '0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0;
    init2 = 1'b0; key2 = '0; nonce2 = '0; ctr_init2 = '0;
    in_valid2 = 1'b0; in_data2 = '0; in_last2 = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", ctr_overflow, 1'b0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // RFC 8439 block, counter 1
    pulse_init(key_rfc, nonce_rfc, 64'd1);
    wait_ready(n);
    check("rfc_first_ready", n, 22);
    fill_rfc(0);
    run_table("rfc");
    check("rfc_busy_end", busy, 1'b0);

    // all-zero inputs over two blocks
    blk0 = ref_block('0, 32'd0, 32'd0, 32'd0, 32'd0, 20);
    blk1 = ref_block('0, 32'd1, 32'd0, 32'd0, 32'd0, 20);
    tv_n = 32;
    for (int i = 0; i < 32; i++) begin
      tv[i].din  = 32'h0;
      tv[i].last = (i == 31);
      tv[i].exp  = (i < 16) ? blk0[32*i +: 32]
                            : blk1[32*(i-16) +: 32];
    end
    pulse_init('0, '0, 64'd0);
    wait_ready(n);
    run_table("zero");
    check("zero_beat0", got_q[0][31:0], 32'hade0b876);
    check("zero_beat1", got_q[1][31:0], 32'h903df1a0);
    check("zero_beat_gap", acc_at[15] - acc_at[14], 1);
    check("zero_regen_gap", acc_at[16] - acc_at[15], 22);

    // random backpressure on the RFC block
    bp_en = 1;
    pulse_init(key_rfc, nonce_rfc, 64'd1);
    wait_ready(n);
    fill_rfc(0);
    run_table("bp");
    bp_en = 0;
    repeat (3) @(posedge clk);
    #1;

    // 32-bit counter exhaustion
    blk0 = ref_block(key_rfc, 32'hffffffff, nonce_rfc[31:0],
                     nonce_rfc[63:32], nonce_rfc[95:64], 20);
    tv_n = 16;
    for (int i = 0; i < 16; i++) begin
      tv[i].din  = 32'h0;
      tv[i].last = 1'b0;
      tv[i].exp  = blk0[32*i +: 32];
    end
    pulse_init(key_rfc, nonce_rfc, 64'h0000_0000_ffff_ffff);
    wait_ready(n);
    run_table("ovf");
    push(32'h0, 1'b0, 40, ok, at);
    check("ovf_17th_refused", ok, 1'b0);
    check("ovf_flag", ctr_overflow, 1'b1);
    check("ovf_in_ready", in_ready, 1'b0);
    check("ovf_out_valid", out_valid, 1'b0);
    check("ovf_busy", busy, 1'b0);
    pulse_init('0, '0, 64'd0);
    @(negedge clk);
    check("ovf_cleared", ctr_overflow, 1'b0);
    check("ovf_restart_busy", busy, 1'b1);
    wait_ready(n);

    // init on beat 5 aborts and restarts
    got_q.delete();
    for (int i = 0; i < 5; i++) begin
      push(32'h0, 1'b0, 50, ok, at);
      check($sformatf("abort_accept%0d", i), ok, 1'b1);
    end
    key = key_rfc; nonce = nonce_rfc; ctr_init = 64'd1;
    init = 1'b1; in_valid = 1'b1;
    in_data = 32'hdeadbeef; in_last = 1'b0;
    @(posedge clk); #1;
    init = 1'b0; in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b1);
      end
    end while (!in_ready && n < 100);
    @(posedge clk); #1;
    check("abort_latency", n, 22);
    check("abort_beats_out", got_q.size(), 5);
    check("abort_beat0", got_q[0][31:0], 32'hade0b876);
    check("abort_beat1", got_q[1][31:0], 32'h903df1a0);
    fill_rfc(0);
    run_table("abort");

    // asynchronous reset in the middle of ROUND
    pulse_init(key_rfc, nonce_rfc, 64'd1);
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1'b0);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_data", out_data, 32'h0);
    check("arst_out_last", out_last, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_ovf", ctr_overflow, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("arst_idle_ready", in_ready, 1'b0);
    check("arst_idle_busy", busy, 1'b0);
    pulse_init(key_rfc, nonce_rfc, 64'd1);
    wait_ready(n);
    check("arst_first_ready", n, 22);
    fill_rfc(1);
    run_table("fresh");

    // 8 rounds, 64-bit counter carry, 128-bit beats
    key2 = ~key_rfc;
    nonce2 = 96'hcafef00d_01234567_89abcdef;
    ctr_init2 = 64'h0000_0000_ffff_ffff;
    blk0 = ref_block(key2, 32'hffffffff, 32'h0,
                     nonce2[31:0], nonce2[63:32], 8);
    blk1 = ref_block(key2, 32'h0, 32'h1,
                     nonce2[31:0], nonce2[63:32], 8);
    got2_q.delete();
    init2 = 1'b1;
    @(posedge clk); #1;
    init2 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready2 && n < 100);
    @(posedge clk); #1;
    check("w128_first_ready", n, 10);
    for (int i = 0; i < 8; i++) begin
      d2[i] = {4{32'h11111111 * (i + 1)}};
      push2(d2[i], i == 7, ok);
      check($sformatf("w128_accept%0d", i), ok, 1'b1);
    end
    repeat (3) @(posedge clk);
    #1;
    check("w128_count", got2_q.size(), 8);
    for (int i = 0; i < 8 && i < got2_q.size(); i++) begin
      check($sformatf("w128_data%0d", i), got2_q[i][127:0],
            d2[i] ^ ((i < 4) ? blk0[128*i +: 128]
                             : blk1[128*(i-4) +: 128]));
      check($sformatf("w128_last%0d", i),
            got2_q[i][128], i == 7);
    end
    check("w128_busy_end", busy2, 1'b0);
    check("w128_no_ovf", ovf2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
